// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB first,
// one bit per clock. It uses a full-subtractor slice built from two UDPs plus a
// registered borrow. A start/busy/done handshake delivers the WIDTH-bit
// difference and the final borrow.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-high reset
//   start - operation request, sampled only while idle
//   a, b  - minuend / subtrahend, captured on the accepting edge
//   busy  - high while an operation is in flight or completing
//   done  - one-cycle pulse; diff/bout are valid
//   diff  - a - b mod 2^WIDTH; holds until the next completion
//   bout  - final borrow (1 iff a < b); holds with diff

// Difference bit: ai ^ bi ^ bin
primitive udp_diff (d, ai, bi, bin);
  output d;
  input  ai, bi, bin;
  table
  // ai bi bin : d
     0  0  0   : 0;
     0  0  1   : 1;
     0  1  0   : 1;
     0  1  1   : 0;
     1  0  0   : 1;
     1  0  1   : 0;
     1  1  0   : 0;
     1  1  1   : 1;
  endtable
endprimitive

// Borrow out: (~ai & bi) | (~(ai ^ bi) & bin)
primitive udp_borrow (bo, ai, bi, bin);
  output bo;
  input  ai, bi, bin;
  table
  // ai bi bin : bo
     0  0  0   : 0;
     0  0  1   : 1;
     0  1  0   : 1;
     0  1  1   : 1;
     1  0  0   : 0;
     1  0  1   : 0;
     1  1  0   : 0;
     1  1  1   : 1;
  endtable
endprimitive

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_nxt;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             d;
  logic             bnext;
  logic             last;

  // Full-subtractor slice on the operand LSBs
  udp_diff   u_diff   (d,     sa[0], sb[0], brw);
  udp_borrow u_borrow (bnext, sa[0], sb[0], brw);

  // Result shift-in; a one-bit result is just the slice output
  generate
    if (WIDTH == 1) begin : g_w1
      assign sd_nxt = d;
    end else begin : g_wn
      assign sd_nxt = {d, sd[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      BUSY:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: operand capture, serial shift, result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            brw <= 1'b0;
            cnt <= '0;
          end
        end
        BUSY: begin
          sd  <= sd_nxt;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          brw <= bnext;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= sd_nxt;
            bout <= bnext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: WIDTH=8 and WIDTH=1 instances checked
// against vector tables, hand-written corner sequences and a random run
// compared with a plain-arithmetic reference.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] diff8;
  logic       bout8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] diff1;
  logic       bout1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ed;
    logic       eb;
  } vec8_t;

  typedef struct {
    logic [0:0] a;
    logic [0:0] b;
    logic [0:0] ed;
    logic       eb;
  } vec1_t;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation; returns result and edges from accept to done
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     output logic [7:0] rd, output logic rb, output int lat);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("busy8_after_accept", 32'(busy8), 32'd1);
    lat = 1;
    while (!done8 && lat < 30) begin
      tick();
      if (!done8) lat++;
    end
    if (!done8) begin
      n_checks++; n_fail++;
      $display("FAIL op8_timeout: done never rose for a=0x%0h b=0x%0h", av, bv);
    end
    rd = diff8; rb = bout8;
    tick();
    chk("done8_one_cycle", 32'(done8), 32'd0);
  endtask

  task automatic op1(input logic [0:0] av, input logic [0:0] bv,
                     output logic [0:0] rd, output logic rb, output int lat);
    a1 = av; b1 = bv; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 10) begin
      tick();
      if (!done1) lat++;
    end
    if (!done1) begin
      n_checks++; n_fail++;
      $display("FAIL op1_timeout: done never rose");
    end
    rd = diff1; rb = bout1;
    tick();
    chk("done1_one_cycle", 32'(done1), 32'd0);
  endtask

  initial begin
    vec8_t vt8[6];
    vec1_t vt1[4];
    logic [7:0] rd8;
    logic       rb;
    logic [0:0] rd1;
    int         lat;
    int         last_done;
    int         n_done;
    logic [8:0] ref9;

    vt8[0] = '{a: 8'h05, b: 8'h03, ed: 8'h02, eb: 1'b0};
    vt8[1] = '{a: 8'h03, b: 8'h05, ed: 8'hFE, eb: 1'b1};
    vt8[2] = '{a: 8'h00, b: 8'hFF, ed: 8'h01, eb: 1'b1};
    vt8[3] = '{a: 8'hFF, b: 8'hFF, ed: 8'h00, eb: 1'b0};
    vt8[4] = '{a: 8'h80, b: 8'h01, ed: 8'h7F, eb: 1'b0};
    vt8[5] = '{a: 8'h00, b: 8'h01, ed: 8'hFF, eb: 1'b1};

    vt1[0] = '{a: 1'b0, b: 1'b0, ed: 1'b0, eb: 1'b0};
    vt1[1] = '{a: 1'b0, b: 1'b1, ed: 1'b1, eb: 1'b1};
    vt1[2] = '{a: 1'b1, b: 1'b0, ed: 1'b1, eb: 1'b0};
    vt1[3] = '{a: 1'b1, b: 1'b1, ed: 1'b0, eb: 1'b0};

    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_diff8", 32'(diff8), 32'd0);
    chk("reset_bout8", 32'(bout8), 32'd0);
    chk("reset_busy1", 32'(busy1), 32'd0);

    // Directed vectors, WIDTH=8
    for (int i = 0; i < 6; i++) begin
      op8(vt8[i].a, vt8[i].b, rd8, rb, lat);
      chk($sformatf("vec8[%0d]_diff", i), 32'(rd8), 32'(vt8[i].ed));
      chk($sformatf("vec8[%0d]_bout", i), 32'(rb), 32'(vt8[i].eb));
      chk($sformatf("vec8[%0d]_latency", i), 32'(lat), 32'd8);
    end

    // Directed vectors, WIDTH=1
    for (int i = 0; i < 4; i++) begin
      op1(vt1[i].a, vt1[i].b, rd1, rb, lat);
      chk($sformatf("vec1[%0d]_diff", i), 32'(rd1), 32'(vt1[i].ed));
      chk($sformatf("vec1[%0d]_bout", i), 32'(rb), 32'(vt1[i].eb));
      chk($sformatf("vec1[%0d]_latency", i), 32'(lat), 32'd1);
    end

    // Operands scrambled every cycle while busy must not affect the result
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      lat++;
    end
    chk("scramble_done", 32'(done8), 32'd1);
    chk("scramble_diff", 32'(diff8), 32'h7F);
    chk("scramble_bout", 32'(bout8), 32'd0);
    tick();

    // start held high: accepted only from idle, one op per 10 cycles
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    last_done = -1; n_done = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      tick();
      if (done8) begin
        chk("held_diff", 32'(diff8), 32'h0F);
        chk("held_bout", 32'(bout8), 32'd0);
        if (last_done >= 0) chk("held_period", 32'(cyc - last_done), 32'd10);
        last_done = cyc;
        n_done++;
      end else if (n_done > 0) begin
        chk("held_diff_hold", 32'(diff8), 32'h0F);
      end
    end
    chk("held_done_count", 32'(n_done), 32'd4);
    start8 = 1'b0;
    while (busy8 && lat < 100) begin tick(); lat++; end

    // Reset during an operation, with start asserted alongside reset
    a8 = 8'h55; b8 = 8'hAA; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    chk("midrst_diff", 32'(diff8), 32'd0);
    chk("midrst_bout", 32'(bout8), 32'd0);
    n_done = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (done8 || busy8) n_done++;
    end
    chk("midrst_no_activity", 32'(n_done), 32'd0);
    op8(8'h0A, 8'h04, rd8, rb, lat);
    chk("postrst_diff", 32'(rd8), 32'h06);
    chk("postrst_bout", 32'(rb), 32'd0);

    // Random operands against (WIDTH+1)-bit arithmetic reference
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb8;
      ra  = 8'($urandom);
      rb8 = 8'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb8};
      op8(ra, rb8, rd8, rb, lat);
      chk($sformatf("rand[%0d]_diff a=%0h b=%0h", i, ra, rb8), 32'(rd8), 32'(ref9[7:0]));
      chk($sformatf("rand[%0d]_bout a=%0h b=%0h", i, ra, rb8), 32'(rb), 32'(ref9[8]));
      chk($sformatf("rand[%0d]_latency", i), 32'(lat), 32'd8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
